pipe_ctrl: RTL

- Central pipeline sequencer for the 5-stage RISC-V core.
- Collects jump/branch redirects from ex, multi-cycle hold requests from ex, and fetch-bus stalls.
- Drives a single encoded hold level to pc_reg, if_id and id_ex, plus a multi-cycle flush for wrong-path squashing and the PC redirect.
- Keeps a saturating stall-cycle counter and a sticky hold-timeout flag for debug.

---
 rtl/pipe_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline sequencer for the 5-stage core.
// Merges ex redirects, ex multi-cycle holds and fetch-bus stalls into one
// hold level, a multi-cycle wrong-path flush and the PC redirect, and keeps
// a saturating lost-cycle counter plus a sticky ex-hold timeout flag.
module pipe_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned MAX_HOLD     = 64
) (
    input  logic        i_Clk,
    input  logic        i_reset,
    input  logic        i_jump_flag,
    input  logic [31:0] i_jump_addr,
    input  logic        i_ex_hold_req,
    input  logic        i_bus_stall,
    input  logic        i_cnt_clr,
    output logic [2:0]  o_hold_flag,
    output logic        o_flush,
    output logic        o_jump_flag,
    output logic [31:0] o_jump_addr,
    output logic [31:0] o_stall_cycles,
    output logic        o_hold_timeout
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        EXHOLD = 2'd2
    } state_t;

    localparam logic [3:0]  FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [15:0] MAX_HOLD_W   = 16'(MAX_HOLD);

    state_t      state_q, state_d;
    logic [3:0]  flush_cnt_q, flush_cnt_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;
    logic [31:0] stall_q, stall_d;
    logic        timeout_q, timeout_d;
    logic [31:0] jaddr_q, jaddr_d;
    logic        flush_active;
    logic        ex_hold;

    // Output decode and next-state: jump > flush > ex hold > bus stall.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        jaddr_d     = jaddr_q;

        flush_active = i_jump_flag || (state_q == FLUSH);
        // A squashed (or being-squashed) instruction cannot be busy.
        ex_hold      = i_ex_hold_req && !flush_active;

        o_jump_flag = i_jump_flag;
        o_jump_addr = i_jump_flag ? i_jump_addr : jaddr_q;
        o_flush     = flush_active;
        if (ex_hold) begin
            o_hold_flag = 3'd3;
        end else if (i_bus_stall) begin
            o_hold_flag = 3'd2;
        end else begin
            o_hold_flag = 3'd0;
        end

        if (i_jump_flag) begin
            jaddr_d    = i_jump_addr;
            hold_cnt_d = '0;
            if (FLUSH_CYCLES <= 1) begin
                state_d     = RUN;
                flush_cnt_d = '0;
            end else begin
                state_d     = FLUSH;
                flush_cnt_d = FLUSH_RELOAD;
            end
        end else if (state_q == FLUSH) begin
            hold_cnt_d = '0;
            if (flush_cnt_q <= 4'd1) begin
                state_d     = RUN;
                flush_cnt_d = '0;
            end else begin
                flush_cnt_d = flush_cnt_q - 4'd1;
            end
        end else if (i_ex_hold_req) begin
            state_d = EXHOLD;
            if (hold_cnt_q != MAX_HOLD_W) begin
                hold_cnt_d = hold_cnt_q + 16'd1;
            end
        end else begin
            state_d    = RUN;
            hold_cnt_d = '0;
        end

        // Timeout latches on the same edge the hold count reaches MAX_HOLD.
        if (i_cnt_clr) begin
            timeout_d = 1'b0;
        end else begin
            timeout_d = timeout_q || (ex_hold && (hold_cnt_d == MAX_HOLD_W));
        end

        if (i_cnt_clr) begin
            stall_d = '0;
        end else if (((o_hold_flag != 3'd0) || flush_active) && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge i_Clk) begin
        if (i_reset) begin
            state_q     <= RUN;
            flush_cnt_q <= '0;
            hold_cnt_q  <= '0;
            stall_q     <= '0;
            timeout_q   <= 1'b0;
            jaddr_q     <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            stall_q     <= stall_d;
            timeout_q   <= timeout_d;
            jaddr_q     <= jaddr_d;
        end
    end

    assign o_stall_cycles = stall_q;
    assign o_hold_timeout = timeout_q;

endmodule
